// File: rtl/microwave_timer_ctrl_pkg.sv
// ============================================================================
//  Module      : microwave_pkg
//  Description : Shared types and constants for the microwave cooking timer:
//                FSM state encoding, BCD digit / MM:SS types, seconds clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package microwave_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef logic [3:0]  bcd_t;
    typedef logic [15:0] mmss_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam int   BEEP_SECS    = 3;

    // Keypad entry allows 60..99 in the seconds field; clamp it to 59.
    function automatic mmss_t sat_seconds(input mmss_t t);
        mmss_t r;
        r = t;
        if (t[7:4] > SEC_TENS_MAX) begin
            r[7:0] = 8'h59;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_mmss_dec.sv
// ============================================================================
//  Module      : bcd_mmss_dec
//  Description : Combinational MM:SS BCD decrement by one second. Seconds
//                units borrow 0->9, seconds tens borrow 0->5, minutes borrow
//                from seconds. is_zero_o flags a result of 00:00.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mmss_dec
    import microwave_pkg::*;
(
    input  mmss_t time_i,
    output mmss_t time_o,
    output logic  is_zero_o
);

    bcd_t sec_u;
    bcd_t sec_t;
    bcd_t min_u;
    bcd_t min_t;

    // Ripple the borrow from seconds units up through the minutes tens.
    always_comb begin
        sec_u = time_i[3:0];
        sec_t = time_i[7:4];
        min_u = time_i[11:8];
        min_t = time_i[15:12];
        if (sec_u != 4'd0) begin
            sec_u = sec_u - 4'd1;
        end else begin
            sec_u = 4'd9;
            if (sec_t != 4'd0) begin
                sec_t = sec_t - 4'd1;
            end else begin
                sec_t = SEC_TENS_MAX;
                if (min_u != 4'd0) begin
                    min_u = min_u - 4'd1;
                end else begin
                    min_u = 4'd9;
                    min_t = min_t - 4'd1;
                end
            end
        end
        time_o    = {min_t, min_u, sec_t, sec_u};
        is_zero_o = (time_o == 16'h0000);
    end

endmodule

`default_nettype wire

// File: rtl/microwave_timer_ctrl.sv
// ============================================================================
//  Module      : microwave_timer_ctrl
//  Description : Microwave cooking-timer controller. Keypad MM:SS entry,
//                quick start, tick-prescaled BCD countdown and magnetron
//                enable sequencing through IDLE/SET/COOK/PAUSE/DONE.
//                Optional alarm output enabled by defining MICROWAVE_BEEP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 10,
    parameter logic [7:0]  QUICK_SEC_BCD = 8'h30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        door_closed,
    output logic [15:0] time_bcd,
    output logic [2:0]  state,
    output logic        mag_on,
    output logic        done
`ifdef MICROWAVE_BEEP_EN
    ,
    output logic        beep
`endif
);

    state_t     state_q, state_d;
    mmss_t      time_q, time_d;
    logic [7:0] presc_q, presc_d;
    logic       mag_on_q;
    logic       done_q;

    mmss_t      dec_time;
    logic       dec_zero;
    logic       key_ok;
    logic       presc_wrap;

    assign key_ok     = key_valid && (key_digit <= 4'd9);
    assign presc_wrap = (presc_q == 8'(TICKS_PER_SEC - 1));

    bcd_mmss_dec u_dec (
        .time_i    (time_q),
        .time_o    (dec_time),
        .is_zero_o (dec_zero)
    );

    // Next-state logic; within each state events are tested in priority order.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        if (clear) begin
            state_d = IDLE;
            time_d  = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (start) begin
                        if (door_closed) begin
                            state_d = COOK;
                            time_d  = {8'h00, QUICK_SEC_BCD};
                            presc_d = '0;
                        end
                    end else if (key_ok) begin
                        state_d = SET;
                        time_d  = {12'h000, key_digit};
                    end
                end
                SET: begin
                    if (stop) begin
                        state_d = IDLE;
                        time_d  = '0;
                        presc_d = '0;
                    end else if (start) begin
                        if (door_closed && (time_q != 16'h0000)) begin
                            state_d = COOK;
                            time_d  = sat_seconds(time_q);
                            presc_d = '0;
                        end
                    end else if (key_ok) begin
                        time_d = {time_q[11:0], key_digit};
                    end
                end
                COOK: begin
                    if (stop || !door_closed) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        if (presc_wrap) begin
                            presc_d = '0;
                            time_d  = dec_time;
                            if (dec_zero) begin
                                state_d = DONE;
                            end
                        end else begin
                            presc_d = presc_q + 8'd1;
                        end
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        state_d = IDLE;
                        time_d  = '0;
                        presc_d = '0;
                    end else if (start && door_closed) begin
                        state_d = COOK;
                    end
                end
                DONE: begin
                    if (stop || start || key_ok) begin
                        state_d = IDLE;
                        time_d  = '0;
                        presc_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    time_d  = '0;
                    presc_d = '0;
                end
            endcase
        end
    end

    // State, time and prescaler registers; outputs are decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            time_q   <= '0;
            presc_q  <= '0;
            mag_on_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_q   <= time_d;
            presc_q  <= presc_d;
            mag_on_q <= (state_d == COOK);
            done_q   <= (state_d == DONE);
        end
    end

    assign time_bcd = time_q;
    assign state    = state_q;
    assign mag_on   = mag_on_q;
    assign done     = done_q;

`ifdef MICROWAVE_BEEP_EN
    localparam int BEEP_TICKS = BEEP_SECS * TICKS_PER_SEC;

    logic [9:0] beep_cnt_q, beep_cnt_d;
    logic       beep_q;

    // Load the alarm length on DONE entry, count ticks down, zero on exit.
    always_comb begin
        beep_cnt_d = beep_cnt_q;
        if (state_d != DONE) begin
            beep_cnt_d = '0;
        end else if (state_q != DONE) begin
            beep_cnt_d = 10'(BEEP_TICKS);
        end else if (tick && (beep_cnt_q != 10'd0)) begin
            beep_cnt_d = beep_cnt_q - 10'd1;
        end
    end

    // Alarm counter and registered alarm output.
    always_ff @(posedge clk) begin
        if (reset) begin
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
            beep_q     <= (beep_cnt_d != 10'd0);
        end
    end

    assign beep = beep_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_microwave_timer_ctrl.sv
// ============================================================================
//  Module      : tb_microwave_timer_ctrl
//  Description : Self-checking bench for microwave_timer_ctrl. A behavioural
//                model tracks remaining time as whole seconds and is compared
//                against the DUT every cycle; directed scenarios add literal
//                expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_microwave_timer_ctrl;

    localparam int          TPS   = 10;
    localparam logic [7:0]  QUICK = 8'h30;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        door_closed = 1'b1;
    logic [15:0] time_bcd;
    logic [2:0]  state;
    logic        mag_on;
    logic        done;
    logic        beep_w;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    microwave_timer_ctrl #(
        .TICKS_PER_SEC (TPS),
        .QUICK_SEC_BCD (QUICK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .door_closed (door_closed),
        .time_bcd    (time_bcd),
        .state       (state),
        .mag_on      (mag_on),
        .done        (done)
`ifdef MICROWAVE_BEEP_EN
        ,
        .beep        (beep_w)
`endif
    );

`ifndef MICROWAVE_BEEP_EN
    assign beep_w = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State numbers: 0 idle, 1 set, 2 cook, 3 pause, 4 done.
    int          m_st = 0;
    logic [15:0] m_time = 16'h0000;
    int          m_presc = 0;
    int          m_bcnt = 0;

    function automatic int to_secs(input logic [15:0] t);
        return (10 * t[15:12] + t[11:8]) * 60 + 10 * t[7:4] + t[3:0];
    endfunction

    function automatic logic [15:0] from_secs(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    always @(posedge clk) begin
        bit k;
        int s;
        k = key_valid && (key_digit <= 4'd9);
        if (reset || clear) begin
            m_st = 0; m_time = 16'h0000; m_presc = 0; m_bcnt = 0;
        end else begin
            case (m_st)
                0: if (stop) begin end
                   else if (start) begin
                       if (door_closed) begin m_st = 2; m_time = {8'h00, QUICK}; m_presc = 0; end
                   end else if (k) begin m_st = 1; m_time = {12'h000, key_digit}; end
                1: if (stop) begin m_st = 0; m_time = 16'h0000; end
                   else if (start) begin
                       if (door_closed && m_time != 16'h0000) begin
                           if (m_time[7:4] > 4'd5) m_time[7:0] = 8'h59;
                           m_st = 2; m_presc = 0;
                       end
                   end else if (k) m_time = {m_time[11:0], key_digit};
                2: if (stop || !door_closed) m_st = 3;
                   else if (tick) begin
                       m_presc++;
                       if (m_presc == TPS) begin
                           m_presc = 0;
                           s = to_secs(m_time) - 1;
                           m_time = from_secs(s);
                           if (s == 0) begin m_st = 4; m_bcnt = 3 * TPS; end
                       end
                   end
                3: if (stop) begin m_st = 0; m_time = 16'h0000; end
                   else if (start && door_closed) m_st = 2;
                default: begin
                    if (tick && m_bcnt > 0) m_bcnt--;
                    if (stop || start || k) begin m_st = 0; m_time = 16'h0000; m_bcnt = 0; end
                end
            endcase
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 32'(state), 32'(m_st));
            chk("time_bcd", 32'(time_bcd), 32'(m_time));
            chk("mag_on", 32'(mag_on), 32'(m_st == 2));
            chk("done", 32'(done), 32'(m_st == 4));
`ifdef MICROWAVE_BEEP_EN
            chk("beep", 32'(beep_w), 32'(m_bcnt > 0));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_strobes();
        tick = 1'b0; key_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle_strobes();
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1; key_digit = d; cyc();
    endtask

    task automatic keys(input logic [15:0] ds, input int n);
        for (int i = n - 1; i >= 0; i--) key(ds[4*i +: 4]);
    endtask

    task automatic do_start(); start = 1'b1; cyc(); endtask
    task automatic do_stop();  stop  = 1'b1; cyc(); endtask
    task automatic do_clear(); clear = 1'b1; cyc(); endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc(); cyc();
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_time", 32'(time_bcd), 32'h0000);
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_mag", 32'(mag_on), 32'd0);
        chk("reset_beep", 32'(beep_w), 32'd0);
        reset = 1'b0;
        cyc();

        // Key entry and first second of countdown.
        keys(16'h0130, 3);
        chk("key_entry", 32'(time_bcd), 32'h0130);
        do_start();
        chk("start_mag", 32'(mag_on), 32'd1);
        chk("start_time", 32'(time_bcd), 32'h0130);
        ticks(10);
        chk("first_sec", 32'(time_bcd), 32'h0129);
        do_clear();
        chk("clear_time", 32'(time_bcd), 32'h0000);

        // Borrow chain.
        keys(16'h0100, 3);
        do_start();
        ticks(10);
        chk("borrow", 32'(time_bcd), 32'h0059);
        do_clear();
        key(4'd1);
        do_start();
        ticks(9);
        chk("pre_final_mag", 32'(mag_on), 32'd1);
        tick = 1'b1; cyc();
        chk("final_done", 32'(done), 32'd1);
        chk("final_mag", 32'(mag_on), 32'd0);
        chk("final_time", 32'(time_bcd), 32'h0000);
`ifdef MICROWAVE_BEEP_EN
        chk("beep_on", 32'(beep_w), 32'd1);
`endif
        cyc();
        ticks(29);
`ifdef MICROWAVE_BEEP_EN
        chk("beep_29", 32'(beep_w), 32'd1);
`endif
        ticks(1);
`ifdef MICROWAVE_BEEP_EN
        chk("beep_30", 32'(beep_w), 32'd0);
`endif
        key(4'd5);
        chk("done_exit", 32'(state), 32'd0);
        chk("done_exit_time", 32'(time_bcd), 32'h0000);

        // Second DONE; a key during the alarm drops it.
        key(4'd1);
        do_start();
        ticks(15);
        key(4'd7);
        chk("key_in_beep", 32'(state), 32'd0);
        chk("key_in_beep_b", 32'(beep_w), 32'd0);

        // Door opening mid-second.
        keys(16'h0020, 2);
        do_start();
        ticks(4);
        door_closed = 1'b0; cyc();
        chk("door_pause", 32'(state), 32'd3);
        chk("door_mag", 32'(mag_on), 32'd0);
        ticks(2);
        key(4'd3);
        chk("pause_held", 32'(time_bcd), 32'h0020);
        door_closed = 1'b1; cyc();
        do_start();
        ticks(5);
        chk("resume_5", 32'(time_bcd), 32'h0020);
        ticks(1);
        chk("resume_6", 32'(time_bcd), 32'h0019);
        do_stop();
        do_stop();
        chk("pause_stop", 32'(state), 32'd0);

        // Quick start and saturation.
        do_start();
        chk("quick", 32'(time_bcd), 32'h0030);
        chk("quick_st", 32'(state), 32'd2);
        do_clear();
        key(4'hc);
        chk("bad_digit", 32'(state), 32'd0);
        keys(16'h9999, 4);
        chk("entry_9999", 32'(time_bcd), 32'h9999);
        do_start();
        chk("sat", 32'(time_bcd), 32'h9959);

        // Stop and tick together: tick dropped, prescaler kept.
        ticks(3);
        stop = 1'b1; tick = 1'b1; cyc();
        chk("stop_tick", 32'(state), 32'd3);
        do_start();
        ticks(6);
        chk("presc_kept6", 32'(time_bcd), 32'h9959);
        ticks(1);
        chk("presc_kept7", 32'(time_bcd), 32'h9958);
        do_clear();
        chk("clear_cook", 32'(mag_on), 32'd0);
        chk("clear_cook_t", 32'(time_bcd), 32'h0000);

        // Start ignored with zero time and with door open.
        key(4'd0);
        do_start();
        chk("start_zero", 32'(state), 32'd1);
        key(4'd4);
        door_closed = 1'b0; cyc();
        do_start();
        chk("start_door", 32'(state), 32'd1);
        door_closed = 1'b1;
        do_stop();
        chk("set_stop", 32'(time_bcd), 32'h0000);

        // Reset mid-cook.
        do_start();
        ticks(3);
        reset = 1'b1; cyc();
        chk("reset_cook", 32'(state), 32'd0);
        chk("reset_cook_m", 32'(mag_on), 32'd0);
        reset = 1'b0;
        cyc();
        cyc();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
